random_spawn_scheduler: RTL and testbench

- Consumer side of the random-number interface. Drives the generator's bound (max_value) and samples its 9-bit output (random_output) on a fixed period.
- Validates each sample, maps it to a screen x coordinate, and queues accepted positions.
- Hands positions to game logic (ball/shot spawner) over a valid/ready handshake.

---
 rtl/random_spawn_scheduler_pkg.sv | 23 ++
 rtl/random_spawn_scheduler_spawn_fifo.sv | 67 ++++++
 rtl/random_spawn_scheduler.sv | 141 ++++++++++++++
 tb/tb_random_spawn_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/random_spawn_scheduler_pkg.sv
// Shared constants, FSM encoding and the sample-to-screen mapping helper
// for the random spawn scheduler.
package random_spawn_scheduler_pkg;

    localparam int H_RES         = 640;
    localparam int X_W           = 10;
    localparam int RAND_W        = 9;
    localparam int DEFAULT_RANGE = 400;
    localparam int DEFAULT_X_MIN = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2
    } sched_state_e;

    // Accepted sample shifted right by the screen margin, zero-extended.
    function automatic logic [X_W-1:0] to_screen_x(input logic [RAND_W-1:0] sample,
                                                   input int x_min);
        return X_W'(x_min) + X_W'(sample);
    endfunction

endpackage

// File: rtl/random_spawn_scheduler_spawn_fifo.sv
// Small synchronous FIFO holding accepted spawn positions.
// Full/empty come from registered occupancy, so a push is never visible on
// the head in the same cycle (no bypass) and a full queue refuses a push
// even when a pop happens in that cycle. flush wins over push.
module spawn_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset because head is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/random_spawn_scheduler.sv
// Samples the random generator every SAMPLE_DELAY+1 cycles, rejects
// out-of-range and repeated values, and queues accepted x positions for the
// spawner.
// Handshake: the head entry is offered on spawn_x while spawn_valid=1 and is
// held stable until the cycle in which spawn_valid && spawn_ready, when it is
// consumed at the clock edge; spawn_ready while spawn_valid=0 has no effect.
module random_spawn_scheduler
    import random_spawn_scheduler_pkg::*;
#(
    parameter int SAMPLE_DELAY = 2000000,
    parameter int RANGE        = DEFAULT_RANGE,
    parameter int X_MIN        = DEFAULT_X_MIN,
    parameter int DEPTH        = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic [RAND_W-1:0] rand_in,
    output logic [31:0]       max_value,
    output logic [X_W-1:0]    spawn_x,
    output logic              spawn_valid,
    input  logic              spawn_ready,
    output logic [7:0]        drop_count,
    output logic [7:0]        reject_count,
    output sched_state_e      fsm_state
);

    localparam int CNT_W = (SAMPLE_DELAY > 1) ? $clog2(SAMPLE_DELAY) : 1;

    sched_state_e      state;
    logic [CNT_W-1:0]  tick_cnt;
    logic [RAND_W-1:0] sample_q;
    logic [RAND_W-1:0] last_q;
    logic              last_valid;

    logic              in_check;
    logic              out_of_range;
    logic              is_repeat;
    logic              do_accept;
    logic              do_drop;
    logic              do_reject;
    logic              fifo_full;
    logic              fifo_empty;

    assign max_value   = 32'(RANGE);
    assign fsm_state   = state;
    assign spawn_valid = !fifo_empty;

    // Sample decision for the CHECK cycle, in priority order:
    // range, repeat, then queue space.
    always_comb begin
        in_check     = (state == ST_CHECK);
        out_of_range = (int'(sample_q) >= RANGE);
        is_repeat    = last_valid && (sample_q == last_q);
        do_reject    = in_check && (out_of_range || is_repeat);
        do_drop      = in_check && !out_of_range && !is_repeat && fifo_full;
        do_accept    = in_check && !out_of_range && !is_repeat && !fifo_full;
    end

    // Sampling FSM with period counter; captures rand_in at terminal count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            sample_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tick_cnt <= '0;
                    if (enable) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!enable) begin
                        state    <= ST_IDLE;
                        tick_cnt <= '0;
                    end else if (tick_cnt == CNT_W'(SAMPLE_DELAY - 1)) begin
                        state    <= ST_CHECK;
                        tick_cnt <= '0;
                        sample_q <= rand_in;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    state <= enable ? ST_WAIT : ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

    // Last-accepted memory used for repeat rejection; flush forgets it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q     <= '0;
            last_valid <= 1'b0;
        end else if (flush) begin
            last_valid <= 1'b0;
        end else if (do_accept) begin
            last_q     <= sample_q;
            last_valid <= 1'b1;
        end
    end

    // Saturating loss counters; only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count   <= '0;
            reject_count <= '0;
        end else begin
            if (do_drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 1'b1;
            end
            if (do_reject && (reject_count != 8'hFF)) begin
                reject_count <= reject_count + 1'b1;
            end
        end
    end

    spawn_fifo #(
        .DEPTH (DEPTH),
        .W     (X_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (do_accept),
        .push_data (to_screen_x(sample_q, X_MIN)),
        .pop       (spawn_ready),
        .flush     (flush),
        .head      (spawn_x),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_random_spawn_scheduler.sv
// Directed bench for random_spawn_scheduler (SAMPLE_DELAY=4, RANGE=400,
// X_MIN=16, DEPTH=4). Inputs change and outputs are sampled on the falling
// edge; the DUT acts on the rising edge.
module tb_random_spawn_scheduler;
    import random_spawn_scheduler_pkg::*;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         flush;
    logic [8:0]   rand_in;
    logic [31:0]  max_value;
    logic [9:0]   spawn_x;
    logic         spawn_valid;
    logic         spawn_ready;
    logic [7:0]   drop_count;
    logic [7:0]   reject_count;
    sched_state_e fsm_state;

    int n_cmp;
    int n_err;
    logic [9:0] exp_q[$];

    random_spawn_scheduler #(
        .SAMPLE_DELAY (4),
        .RANGE        (400),
        .X_MIN        (16),
        .DEPTH        (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .flush        (flush),
        .rand_in      (rand_in),
        .max_value    (max_value),
        .spawn_x      (spawn_x),
        .spawn_valid  (spawn_valid),
        .spawn_ready  (spawn_ready),
        .drop_count   (drop_count),
        .reject_count (reject_count),
        .fsm_state    (fsm_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_valid"},  32'(spawn_valid), 32'd0);
        check_eq({tag, "_x"},      32'(spawn_x), 32'd0);
        check_eq({tag, "_drop"},   32'(drop_count), 32'd0);
        check_eq({tag, "_reject"}, 32'(reject_count), 32'd0);
        check_eq({tag, "_state"},  32'(fsm_state), 32'(ST_IDLE));
        check_eq({tag, "_max"},    max_value, 32'd400);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b0;
        enable      = 1'b0;
        flush       = 1'b0;
        spawn_ready = 1'b0;
        rand_in     = '0;
        exp_q.delete();
        step();
        check_reset_values("rst");
        step();
        reset = 1'b1;
    endtask

    // Returns on the falling edge of the first CHECK cycle seen.
    task automatic wait_check(input string tag);
        int k;
        k = 0;
        while (fsm_state != ST_CHECK && k < 20) begin
            step();
            k++;
        end
        if (fsm_state != ST_CHECK) begin
            check_eq({tag, "_timeout"}, 32'(fsm_state), 32'(ST_CHECK));
        end
    endtask

    // Presents a value, lets it be captured and decided; returns after the
    // decision edge.
    task automatic run_sample(input logic [8:0] v, input string tag);
        rand_in = v;
        wait_check(tag);
        step();
    endtask

    // Pops every expected entry in order, then confirms the queue is empty.
    task automatic drain(input string tag);
        logic [9:0] e;
        spawn_ready = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq({tag, "_valid"}, 32'(spawn_valid), 32'd1);
            check_eq({tag, "_x"}, 32'(spawn_x), 32'(e));
            step();
        end
        check_eq({tag, "_empty"}, 32'(spawn_valid), 32'd0);
        spawn_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        enable = 1'b0;
        flush = 1'b0;
        spawn_ready = 1'b0;
        rand_in = '0;

        // Test 1: constant 10, ready high: one push, later repeats rejected.
        do_reset();
        enable = 1'b1;
        rand_in = 9'd10;
        spawn_ready = 1'b1;
        check_eq("t1_idle", 32'(fsm_state), 32'(ST_IDLE));
        for (int cyc = 1; cyc <= 16; cyc++) begin
            step();
            check_eq($sformatf("t1_valid_c%0d", cyc), 32'(spawn_valid), (cyc == 6) ? 32'd1 : 32'd0);
            if (cyc == 4) check_eq("t1_wait", 32'(fsm_state), 32'(ST_WAIT));
            if (cyc == 5) check_eq("t1_check", 32'(fsm_state), 32'(ST_CHECK));
            if (cyc == 6) check_eq("t1_x", 32'(spawn_x), 32'd26);
            if (cyc == 11) check_eq("t1_rej1", 32'(reject_count), 32'd1);
            if (cyc == 15) check_eq("t1_check2", 32'(fsm_state), 32'(ST_CHECK));
        end
        check_eq("t1_rej2", 32'(reject_count), 32'd2);
        check_eq("t1_drop", 32'(drop_count), 32'd0);

        // Test 2: fill with ready low, overflow drops, FIFO order on drain.
        do_reset();
        enable = 1'b1;
        for (int v = 5; v <= 10; v++) begin
            run_sample(9'(v), "t2_sample");
            if (v <= 8) exp_q.push_back(10'(16 + v));
        end
        check_eq("t2_drop", 32'(drop_count), 32'd2);
        check_eq("t2_reject", 32'(reject_count), 32'd0);
        enable = 1'b0;
        drain("t2_drain");

        // Test 3: out-of-range rejected, top legal value accepted.
        do_reset();
        enable = 1'b1;
        run_sample(9'd450, "t3_s450");
        check_eq("t3_rej", 32'(reject_count), 32'd1);
        check_eq("t3_novalid", 32'(spawn_valid), 32'd0);
        run_sample(9'd399, "t3_s399");
        exp_q.push_back(10'd415);
        enable = 1'b0;
        drain("t3_drain");

        // Test 4: full queue with pop on the CHECK cycle still drops.
        do_reset();
        enable = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            run_sample(9'(v), "t4_fill");
            exp_q.push_back(10'(16 + v));
        end
        rand_in = 9'd5;
        wait_check("t4_chk");
        spawn_ready = 1'b1;
        enable = 1'b0;
        check_eq("t4_head", 32'(spawn_x), 32'(exp_q.pop_front()));
        step();
        check_eq("t4_drop", 32'(drop_count), 32'd1);
        drain("t4_drain");

        // Test 5: flush empties queue and clears repeat memory.
        do_reset();
        enable = 1'b1;
        run_sample(9'd10, "t5_s10");
        run_sample(9'd11, "t5_s11");
        check_eq("t5_valid_pre", 32'(spawn_valid), 32'd1);
        rand_in = 9'd10;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("t5_flushed", 32'(spawn_valid), 32'd0);
        run_sample(9'd10, "t5_again");
        check_eq("t5_valid", 32'(spawn_valid), 32'd1);
        check_eq("t5_x", 32'(spawn_x), 32'd26);
        check_eq("t5_rej", 32'(reject_count), 32'd0);

        // Test 6: disable mid-WAIT, then asynchronous reset mid-CHECK.
        step();
        enable = 1'b0;
        step();
        check_eq("t6_idle", 32'(fsm_state), 32'(ST_IDLE));
        check_eq("t6_held", 32'(spawn_x), 32'd26);
        enable = 1'b1;
        rand_in = 9'd77;
        wait_check("t6_chk");
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("t6_async");
        @(negedge clk);
        enable = 1'b0;
        reset = 1'b1;
        step();
        check_reset_values("t6_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
